// File: rtl/coeff_mem_arbiter.sv
// Round-robin, burst-limited arbiter that shares one single-port coefficient SRAM
// between the expansion writer and the downstream reader. SRAM pins are driven from registers.
module coeff_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 24,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_gnt,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              WEB,
    output logic              CEB,
    input  logic [DATA_W-1:0] Q
);

    typedef enum logic {
        WRITER = 1'b0,
        READER = 1'b1
    } owner_t;

    owner_t      last_owner;
    owner_t      gnt_owner;
    logic [3:0]  run_cnt;
    logic        burst_ok;
    logic [RD_LAT:0] vld_pipe;

    assign burst_ok  = (run_cnt < 4'(MAX_BURST));
    assign gnt_owner = r_gnt ? READER : WRITER;

    // Grant decision; both grants are held low while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_gnt = 1'b0;
        r_gnt = 1'b0;
        if (!rst) begin
            if (w_req && r_req) begin
                if (last_owner == WRITER) begin
                    w_gnt = burst_ok;
                    r_gnt = !burst_ok;
                end else begin
                    r_gnt = burst_ok;
                    w_gnt = !burst_ok;
                end
            end else begin
                w_gnt = w_req;
                r_gnt = r_req;
            end
        end
    end

    // Ownership and run-length tracking; run_cnt clears whenever the SRAM idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            last_owner <= WRITER;
            run_cnt    <= 4'd0;
        end else if (w_gnt || r_gnt) begin
            if (gnt_owner == last_owner)
                run_cnt <= (run_cnt == 4'hF) ? run_cnt : run_cnt + 4'd1;
            else
                run_cnt <= 4'd1;
            last_owner <= gnt_owner;
        end else begin
            run_cnt <= 4'd0;
        end
    end

    // SRAM pin registers: a grant in one cycle becomes the memory access of the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A   <= '0;
            D   <= '0;
            WEB <= 1'b1;
            CEB <= 1'b1;
        end else if (w_gnt) begin
            A   <= w_addr;
            D   <= w_data;
            WEB <= 1'b0;
            CEB <= 1'b0;
        end else if (r_gnt) begin
            A   <= r_addr;
            WEB <= 1'b1;
            CEB <= 1'b0;
        end else begin
            WEB <= 1'b1;
            CEB <= 1'b1;
        end
    end

    // Read-valid shift register: one stage for the pin register plus RD_LAT SRAM stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[RD_LAT-1:0], r_gnt};
    end

    assign r_valid = vld_pipe[RD_LAT];
    assign r_data  = r_valid ? Q : '0;

endmodule

// File: tb/tb_coeff_mem_arbiter.sv
// Directed bench for coeff_mem_arbiter: a RD_LAT=1 instance with a behavioural SRAM
// and a RD_LAT=3 instance whose SRAM returns a tagged copy of the address.
module tb_coeff_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          tests = 0;
    int          fails = 0;

    logic        w_req, r_req, w_gnt, r_gnt, r_valid, WEB, CEB;
    logic [15:0] w_addr, r_addr, A;
    logic [23:0] w_data, r_data, D, Q;

    logic        w_req3, r_req3, w_gnt3, r_gnt3, r_valid3, WEB3, CEB3;
    logic [15:0] w_addr3, r_addr3, A3;
    logic [23:0] w_data3, r_data3, D3, Q3;

    logic [23:0] mem [0:255];
    logic [23:0] qp3 [0:2];

    always #5 clk = ~clk;

    coeff_mem_arbiter #(.ADDR_W(16), .DATA_W(24), .RD_LAT(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt),
        .r_data(r_data), .r_valid(r_valid),
        .A(A), .D(D), .WEB(WEB), .CEB(CEB), .Q(Q)
    );

    coeff_mem_arbiter #(.ADDR_W(16), .DATA_W(24), .RD_LAT(3), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst(rst),
        .w_req(w_req3), .w_addr(w_addr3), .w_data(w_data3), .w_gnt(w_gnt3),
        .r_req(r_req3), .r_addr(r_addr3), .r_gnt(r_gnt3),
        .r_data(r_data3), .r_valid(r_valid3),
        .A(A3), .D(D3), .WEB(WEB3), .CEB(CEB3), .Q(Q3)
    );

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (!CEB && !WEB) mem[A[7:0]] <= D;
        if (!CEB && WEB)  Q <= mem[A[7:0]];
    end

    // Three-cycle-latency SRAM that returns 0x300000 | address.
    assign Q3 = qp3[2];
    always @(posedge clk) begin
        if (!CEB3 && WEB3) qp3[0] <= 24'h300000 | {8'h00, A3};
        qp3[1] <= qp3[0];
        qp3[2] <= qp3[1];
    end

    task automatic test_reset();
        rst = 1'b1;
        w_req = 1'b1; r_req = 1'b1; w_addr = '0; r_addr = '0; w_data = '0;
        w_req3 = 1'b0; r_req3 = 1'b0; w_addr3 = '0; r_addr3 = '0; w_data3 = '0;
        #2;
        tests++; if (w_gnt !== 1'b0) begin fails++; $display("FAIL reset_w_gnt: got %b want 0", w_gnt); end
        tests++; if (r_gnt !== 1'b0) begin fails++; $display("FAIL reset_r_gnt: got %b want 0", r_gnt); end
        tests++; if (A !== 16'h0 || D !== 24'h0) begin fails++; $display("FAIL reset_AD: got A=%0h D=%0h want 0 0", A, D); end
        tests++; if (WEB !== 1'b1 || CEB !== 1'b1) begin fails++; $display("FAIL reset_pins: got WEB=%b CEB=%b want 1 1", WEB, CEB); end
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
        w_req = 1'b0; r_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_stream();
        for (int n = 0; n <= 256; n++) begin
            w_req  = (n < 256);
            w_addr = 16'(n);
            w_data = 24'(n + 'h100);
            @(negedge clk);
            if (n < 256) begin
                tests++; if (w_gnt !== 1'b1 || r_gnt !== 1'b0) begin fails++; $display("FAIL wstream_gnt[%0d]: got w=%b r=%b want 1 0", n, w_gnt, r_gnt); end
            end
            tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL wstream_r_valid[%0d]: got %b want 0", n, r_valid); end
            if (n > 0) begin
                tests++;
                if (A !== 16'(n - 1) || D !== 24'(n - 1 + 'h100) || WEB !== 1'b0 || CEB !== 1'b0) begin
                    fails++;
                    $display("FAIL wstream_pins[%0d]: got A=%0h D=%0h WEB=%b CEB=%b want A=%0h D=%0h 0 0",
                             n, A, D, WEB, CEB, n - 1, n - 1 + 'h100);
                end
            end
            @(posedge clk); #1;
        end
        w_req = 1'b0;
    endtask

    task automatic test_read_stream();
        for (int c = 0; c < 12; c++) begin
            r_req  = (c < 8);
            r_addr = 16'(c);
            @(negedge clk);
            tests++; if (r_gnt !== (c < 8)) begin fails++; $display("FAIL rstream_gnt[%0d]: got %b want %b", c, r_gnt, (c < 8)); end
            if (c >= 1 && c <= 8) begin
                tests++;
                if (A !== 16'(c - 1) || WEB !== 1'b1 || CEB !== 1'b0) begin
                    fails++; $display("FAIL rstream_pins[%0d]: got A=%0h WEB=%b CEB=%b want %0h 1 0", c, A, WEB, CEB, c - 1);
                end
            end
            tests++; if (r_valid !== (c >= 2 && c < 10)) begin fails++; $display("FAIL rstream_valid[%0d]: got %b want %b", c, r_valid, (c >= 2 && c < 10)); end
            if (c >= 2 && c < 10) begin
                tests++; if (r_data !== 24'(c - 2 + 'h100)) begin fails++; $display("FAIL rstream_data[%0d]: got %0h want %0h", c, r_data, c - 2 + 'h100); end
            end
            @(posedge clk); #1;
        end
        r_req = 1'b0;
    endtask

    task automatic test_round_robin();
        int  nw = 0;
        int  nr = 0;
        int  wc = 0;
        int  rc = 0;
        logic exp_w;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            w_req  = (i < 16);
            r_req  = (i < 16);
            w_addr = 16'('h40 + wc);
            w_data = 24'('h500 + wc);
            r_addr = 16'('h40 + rc);
            @(negedge clk);
            exp_w = (i < 16) && ((i / 4) % 2 == 0);
            tests++;
            if (w_gnt !== exp_w || r_gnt !== ((i < 16) && !exp_w)) begin
                fails++; $display("FAIL rr_gnt[%0d]: got w=%b r=%b want w=%b r=%b", i, w_gnt, r_gnt, exp_w, (i < 16) && !exp_w);
            end
            if (i >= 1) begin
                if (!CEB && !WEB) nw++;
                if (!CEB && WEB)  nr++;
            end
            if (w_gnt) wc++;
            if (r_gnt) rc++;
            @(posedge clk); #1;
        end
        w_req = 1'b0; r_req = 1'b0;
        tests++; if (nw != 8) begin fails++; $display("FAIL rr_write_cycles: got %0d want 8", nw); end
        tests++; if (nr != 8) begin fails++; $display("FAIL rr_read_cycles: got %0d want 8", nr); end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_write_then_read();
        for (int c = 0; c < 6; c++) begin
            w_req  = (c == 0);
            w_addr = 16'h5;
            w_data = 24'hABCDE;
            r_req  = (c == 1);
            r_addr = 16'h5;
            @(negedge clk);
            if (c == 0) begin tests++; if (w_gnt !== 1'b1) begin fails++; $display("FAIL raw_w_gnt: got %b want 1", w_gnt); end end
            if (c == 1) begin tests++; if (r_gnt !== 1'b1) begin fails++; $display("FAIL raw_r_gnt: got %b want 1", r_gnt); end end
            if (c == 2) begin
                tests++; if (A !== 16'h5 || WEB !== 1'b1 || CEB !== 1'b0) begin fails++; $display("FAIL raw_read_pins: got A=%0h WEB=%b CEB=%b want 5 1 0", A, WEB, CEB); end
            end
            tests++; if (r_valid !== (c == 3)) begin fails++; $display("FAIL raw_valid[%0d]: got %b want %b", c, r_valid, (c == 3)); end
            if (c == 3) begin tests++; if (r_data !== 24'hABCDE) begin fails++; $display("FAIL raw_data: got %0h want abcde", r_data); end end
            @(posedge clk); #1;
        end
        w_req = 1'b0; r_req = 1'b0;
    endtask

    task automatic test_reset_inflight();
        r_req = 1'b1; r_addr = 16'h30;
        @(negedge clk);
        tests++; if (r_gnt !== 1'b1) begin fails++; $display("FAIL rstinf_gnt0: got %b want 1", r_gnt); end
        @(posedge clk); #1;
        r_addr = 16'h31;
        @(negedge clk);
        tests++; if (r_gnt !== 1'b1) begin fails++; $display("FAIL rstinf_gnt1: got %b want 1", r_gnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (r_gnt !== 1'b0) begin fails++; $display("FAIL rstinf_forced_gnt: got %b want 0", r_gnt); end
        tests++; if (A !== 16'h0 || WEB !== 1'b1 || CEB !== 1'b1) begin fails++; $display("FAIL rstinf_pins: got A=%0h WEB=%b CEB=%b want 0 1 1", A, WEB, CEB); end
        tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rstinf_valid[0]: got %b want 0", r_valid); end
        @(posedge clk); #1;
        rst = 1'b0; r_req = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            tests++; if (r_valid !== 1'b0) begin fails++; $display("FAIL rstinf_valid[%0d]: got %b want 0", c, r_valid); end
            @(posedge clk); #1;
        end
        w_req = 1'b1; w_addr = 16'h9; w_data = 24'h123;
        @(negedge clk);
        tests++; if (w_gnt !== 1'b1) begin fails++; $display("FAIL rstinf_first_gnt: got %b want 1", w_gnt); end
        @(posedge clk); #1;
        w_req = 1'b0;
        @(negedge clk);
        tests++;
        if (A !== 16'h9 || D !== 24'h123 || WEB !== 1'b0 || CEB !== 1'b0) begin
            fails++; $display("FAIL rstinf_first_pins: got A=%0h D=%0h WEB=%b CEB=%b want 9 123 0 0", A, D, WEB, CEB);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_lat3();
        for (int c = 0; c < 10; c++) begin
            r_req3  = (c < 4);
            r_addr3 = 16'('h10 + c);
            @(negedge clk);
            tests++; if (r_gnt3 !== (c < 4)) begin fails++; $display("FAIL lat3_gnt[%0d]: got %b want %b", c, r_gnt3, (c < 4)); end
            tests++; if (r_valid3 !== (c >= 4 && c < 8)) begin fails++; $display("FAIL lat3_valid[%0d]: got %b want %b", c, r_valid3, (c >= 4 && c < 8)); end
            if (c >= 4 && c < 8) begin
                tests++; if (r_data3 !== 24'('h300010 + c - 4)) begin fails++; $display("FAIL lat3_data[%0d]: got %0h want %0h", c, r_data3, 'h300010 + c - 4); end
            end
            @(posedge clk); #1;
        end
        r_req3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_stream();
        test_read_stream();
        test_round_robin();
        test_write_then_read();
        test_reset_inflight();
        test_rd_lat3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
